hypercpu_fetch: RTL and testbench

Instruction fetch stage for hypercpu. Masters the shared memory bus to read sequential instruction words (ROM at low addresses), buffers them in a small prefetch FIFO, and presents them with their addresses to the decode stage over a valid/ready handshake. Accepts PC redirects (jumps, `$pc` writes) and a halt request from execute.

---
 rtl/hypercpu_pkg.sv | 22 ++
 rtl/hypercpu_fetch_fifo.sv | 65 ++++++
 rtl/hypercpu_fetch.sv | 87 ++++++++
 tb/tb_hypercpu_fetch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hypercpu_pkg.sv
// hypercpu shared types for the fetch stage.
//   word_t           : 32-bit machine word / word address
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : fetch control state (RUN, HALTED)
//   fetch_entry_t    : prefetch FIFO entry {addr, data}
package hypercpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    word_t addr;
    word_t data;
  } fetch_entry_t;

endpackage

// File: rtl/hypercpu_fetch_fifo.sv
// hypercpu_fetch_fifo: DEPTH-entry synchronous prefetch FIFO of {addr, data}.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   push        : write push_entry at the tail (ignored when full)
//   pop         : remove the head entry (ignored when empty)
//   flush       : empty the FIFO; overrides push and pop
//   push_entry  : entry to write
//   head        : current head entry (all-zero after reset)
//   count       : number of valid entries, 0..DEPTH
module hypercpu_fetch_fifo
  import hypercpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hypercpu_fetch.sv
// hypercpu_fetch: instruction fetch stage.
// Reads sequential instruction words over the shared memory bus into a
// prefetch FIFO and hands them to decode over a valid/ready handshake.
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   mem_addr          : word address on the shared bus (= fetch_pc)
//   mem_read          : combinational read data from the bus
//   mem_read_enabled  : enables slave read drivers (bus_req && bus_gnt)
//   bus_req, bus_gnt  : bus request / arbiter grant
//   redirect_valid/addr : PC redirect; flushes the FIFO
//   halt              : level request to stop issuing new fetches
//   instr_valid/data/addr, instr_ready : decode handshake
module hypercpu_fetch
  import hypercpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter word_t       RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_read,
  output logic        mem_read_enabled,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state;
  word_t         fetch_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          beat;
  logic          pop;

  // Gating with reset keeps the slave read drivers off while reset is held.
  assign bus_req          = !reset && (state == RUN) && (count < CW'(DEPTH))
                            && !redirect_valid;
  assign mem_read_enabled = bus_req && bus_gnt;
  assign beat             = mem_read_enabled;
  assign mem_addr         = fetch_pc;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_data  = head.data;
  assign instr_addr  = head.addr;

  assign push_entry.addr = fetch_pc;
  assign push_entry.data = mem_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state <= halt ? HALTED : RUN;
      if (redirect_valid) begin
        fetch_pc <= redirect_addr;
      end else if (beat) begin
        fetch_pc <= fetch_pc + 32'd1;
      end
    end
  end

  // A redirect drops bus_req, so flush never coincides with a push.
  hypercpu_fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (beat),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_entry(push_entry),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_hypercpu_fetch.sv
module tb_hypercpu_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_read;
  logic        mem_read_enabled;
  logic        bus_req;
  logic        bus_gnt;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ea;

  hypercpu_fetch #(
    .DEPTH   (2),
    .RESET_PC(32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_read_enabled(mem_read_enabled),
    .bus_req         (bus_req),
    .bus_gnt         (bus_gnt),
    .redirect_valid  (redirect_valid),
    .redirect_addr   (redirect_addr),
    .halt            (halt),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_addr      (instr_addr),
    .instr_ready     (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'hfc21_0000;
      32'h1:   rom = 32'h9cf8_0002;
      32'h2:   rom = 32'hfcff_0002;
      default: rom = (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Bus slave: drives read data only while enabled.
  assign mem_read = mem_read_enabled ? rom(mem_addr) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [31:0] a);
    exp_q.push_back(a);
  endtask

  // Next cycle: drive inputs 1 time unit after the rising edge.
  task automatic drive(input logic g, input logic r, input logic rv,
                       input logic [31:0] ra, input logic h);
    @(posedge clk);
    #1;
    bus_gnt        = g;
    instr_ready    = r;
    redirect_valid = rv;
    redirect_addr  = ra;
    halt           = h;
    #1;
  endtask

  // Scoreboard monitor: every accepted word must match the next expectation.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got addr %h, none expected", instr_addr);
      end else begin
        ea = exp_q.pop_front();
        check("deliver_addr", instr_addr, ea);
        check("deliver_data", instr_data, rom(ea));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; bus_gnt = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_addr = '0; halt = 1'b0;
    #2;
    check("rst_mre", {31'b0, mem_read_enabled}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_data", instr_data, 32'h0);
    check("rst_addr", instr_addr, 32'h0);

    // Streaming from reset; words 0..6 are delivered across the next phases.
    @(posedge clk); #1; reset = 1'b0; #1;
    for (int unsigned i = 0; i < 7; i++) expect_word(i);
    check("post_rst_req", {31'b0, bus_req}, 32'd1);
    check("post_rst_addr", mem_addr, 32'h0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    // Decode stalls: FIFO fills with 3,4.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("full_req", {31'b0, bus_req}, 32'd0);
    check("full_mre", {31'b0, mem_read_enabled}, 32'd0);
    check("full_pc", mem_addr, 32'd5);
    check("full_head", instr_addr, 32'd3);
    drive(1, 0, 0, 0, 0);
    check("full_req2", {31'b0, bus_req}, 32'd0);
    check("full_mre2", {31'b0, mem_read_enabled}, 32'd0);
    drive(1, 1, 0, 0, 0);
    check("drain_req", {31'b0, bus_req}, 32'd0);
    drive(1, 1, 0, 0, 0);
    // Grant withheld three cycles.
    drive(0, 1, 0, 0, 0);
    check("nognt_mre", {31'b0, mem_read_enabled}, 32'd0);
    check("nognt_pc", mem_addr, 32'd6);
    drive(0, 1, 0, 0, 0);
    check("nognt_pc2", mem_addr, 32'd6);
    check("nognt_empty", {31'b0, instr_valid}, 32'd0);
    drive(0, 1, 0, 0, 0);
    check("nognt_pc3", mem_addr, 32'd6);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    // Buffer 7,8 then redirect to 0x0a: both discarded.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 32'h0a, 0);
    check("redir_req", {31'b0, bus_req}, 32'd0);
    check("redir_mre", {31'b0, mem_read_enabled}, 32'd0);
    check("redir_head", instr_addr, 32'd7);
    expect_word(32'h0a);
    expect_word(32'h0b);
    drive(1, 1, 0, 0, 0);
    check("redir_flushed", {31'b0, instr_valid}, 32'd0);
    check("redir_breq", {31'b0, bus_req}, 32'd1);
    check("redir_target", mem_addr, 32'h0a);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // PC wrap.
    drive(0, 1, 1, 32'hFFFF_FFFF, 0);
    expect_word(32'hFFFF_FFFF);
    drive(1, 1, 0, 0, 0);
    check("wrap_addr", mem_addr, 32'hFFFF_FFFF);
    drive(0, 1, 0, 0, 0);
    check("wrap_next", mem_addr, 32'h0);
    check("wrap_head", instr_addr, 32'hFFFF_FFFF);
    // Halt with one entry buffered.
    drive(1, 0, 0, 0, 0);
    expect_word(32'h0);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    check("halt_req", {31'b0, bus_req}, 32'd0);
    check("halt_mre", {31'b0, mem_read_enabled}, 32'd0);
    check("halt_buffered", {31'b0, instr_valid}, 32'd1);
    drive(1, 1, 0, 0, 1);
    check("halt_req2", {31'b0, bus_req}, 32'd0);
    drive(1, 1, 0, 0, 0);
    check("halt_req3", {31'b0, bus_req}, 32'd0);
    check("halt_drained", {31'b0, instr_valid}, 32'd0);
    expect_word(32'h1);
    expect_word(32'h2);
    drive(1, 1, 0, 0, 0);
    check("resume_req", {31'b0, bus_req}, 32'd1);
    check("resume_pc", mem_addr, 32'h1);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    // Asynchronous reset mid-stream (after word 2 is accepted).
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("async_rst_mre", {31'b0, mem_read_enabled}, 32'd0);
    check("async_rst_pc", mem_addr, 32'h0);
    @(posedge clk); #1; reset = 1'b0; #1;
    expect_word(32'h0);
    expect_word(32'h1);
    check("rerst_req", {31'b0, bus_req}, 32'd1);
    check("rerst_pc", mem_addr, 32'h0);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("leftover_expected", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
